// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the bit-serial FSM.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD).
module uart_tx #(
   parameter int unsigned CLK_F      = 50_000_000,
   parameter int unsigned UART_BPS   = 115200,
   parameter int unsigned CLK_GOAL   = CLK_F / UART_BPS,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] uart_data_in,
   input  logic       uart_en,
   output logic       uart_full,
   output logic       uart_busy,
   output logic       uart_done,
   output logic       uart_txd
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = (CLK_GOAL > 1) ? $clog2(CLK_GOAL) : 1;
   localparam logic [TW-1:0] BIT_LAST = TW'(CLK_GOAL - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
      , S_PARITY = 3'd4
`endif
   } state_e;

   // FIFO storage and bookkeeping
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          push, pop;

   // Serializer state
   state_e        state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          bit_end;
`ifdef UART_TX_PARITY_EN
   logic          par_q, par_d;
`else
   logic          unused_parity_odd;
   assign unused_parity_odd = 1'(PARITY_ODD);
`endif

   // Registered outputs
   logic txd_q, txd_d;
   logic busy_q, busy_d;
   logic full_q, full_d;
   logic done_q, done_d;

   assign push    = uart_en && !full_q;
   assign bit_end = (tick_q == BIT_LAST);

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= uart_data_in;
   end

   // FIFO pointer and occupancy update
   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Next-state logic; the FSM pops the head byte whenever it starts a frame
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      tick_d  = (state_q == S_IDLE || bit_end) ? '0 : tick_q + TW'(1);

      case (state_q)
         S_IDLE: begin
            if (cnt_q != '0) begin
               pop     = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_end) state_d = S_DATA;
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) state_d = S_STOP;
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               if (cnt_q != '0) begin
                  pop     = 1'b1;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (pop) begin
         shift_d = mem_q[rd_q];
         bit_d   = '0;
`ifdef UART_TX_PARITY_EN
         par_d   = (^mem_q[rd_q]) ^ 1'(PARITY_ODD);
`endif
      end
   end

   // Output values follow the next state so they line up with state_q
   always_comb begin
      case (state_d)
         S_START:  txd_d = 1'b0;
         S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: txd_d = par_d;
`endif
         default:  txd_d = 1'b1;
      endcase
      done_d = (state_d == S_STOP) && (tick_d == BIT_LAST);
      busy_d = (state_d != S_IDLE) || (cnt_d != '0);
      full_d = (cnt_d == DEPTH_C);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         full_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         full_q  <= full_d;
         done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign uart_txd  = txd_q;
   assign uart_busy = busy_q;
   assign uart_full = full_q;
   assign uart_done = done_q;

endmodule
